// File: rtl/rej_ntt_sampler.sv
// Byte-serial FIPS 204 rejection sampler: SHAKE128 squeeze bytes -> 256 NTT coefficients.
// Optional build macro REJ_STATS_EN adds the rej_count / bytes_used statistics ports.
module rej_ntt_sampler #(
  parameter int unsigned Q       = 32'd8380417,
  parameter int unsigned N       = 32'd256,
  parameter int unsigned COEFF_W = 32'd32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [COEFF_W-1:0] coeff_data,
  output logic [7:0]         coeff_idx,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic               busy,
`ifdef REJ_STATS_EN
  output logic [15:0]        rej_count,
  output logic [15:0]        bytes_used,
`endif
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  localparam logic [23:0] LP_Q    = 24'(Q);
  localparam logic [8:0]  LP_LAST = 9'(N - 32'd1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_byte_cnt;
  logic [7:0]           r_b0;
  logic [7:0]           r_b1;
  logic [22:0]          r_cand;
  logic [8:0]           r_coeff_cnt;
  logic                 r_in_ready;
  logic                 r_coeff_valid;
  logic                 r_busy;
  logic                 r_done;
  logic [COEFF_W-1:0]   r_coeff_data;
  logic [7:0]           r_coeff_idx;
  logic                 w_byte_hs;
  logic                 w_coeff_hs;
  logic                 w_cand_ok;
  logic                 w_last;

  assign w_byte_hs  = r_in_ready & in_valid;
  assign w_coeff_hs = r_coeff_valid & coeff_ready;
  assign w_cand_ok  = ({1'b0, r_cand} < LP_Q);
  assign w_last     = (r_coeff_cnt == LP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_COLLECT;
        else       w_state_nxt = S_IDLE;
      end
      S_COLLECT: begin
        if (w_byte_hs && (r_byte_cnt == 2'd2)) w_state_nxt = S_CHECK;
        else                                   w_state_nxt = S_COLLECT;
      end
      S_CHECK: begin
        if (w_cand_ok) w_state_nxt = S_EMIT;
        else           w_state_nxt = S_COLLECT;
      end
      S_EMIT: begin
        if (w_coeff_hs && w_last) w_state_nxt = S_IDLE;
        else if (w_coeff_hs)      w_state_nxt = S_COLLECT;
        else                      w_state_nxt = S_EMIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte assembly, candidate check and coefficient output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt    <= 2'd0;
      r_b0          <= 8'd0;
      r_b1          <= 8'd0;
      r_cand        <= 23'd0;
      r_coeff_cnt   <= 9'd0;
      r_in_ready    <= 1'b0;
      r_coeff_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_coeff_data  <= '0;
      r_coeff_idx   <= 8'd0;
    end else begin
      // in_ready is registered so it is decoded from the state we are entering
      r_in_ready <= (w_state_nxt == S_COLLECT);
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_byte_cnt  <= 2'd0;
            r_coeff_cnt <= 9'd0;
            r_busy      <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (w_byte_hs) begin
            case (r_byte_cnt)
              2'd0: begin
                r_b0       <= in_data;
                r_byte_cnt <= 2'd1;
              end
              2'd1: begin
                r_b1       <= in_data;
                r_byte_cnt <= 2'd2;
              end
              default: begin
                r_cand     <= {in_data[6:0], r_b1, r_b0};
                r_byte_cnt <= 2'd0;
              end
            endcase
          end
        end
        S_CHECK: begin
          if (w_cand_ok) begin
            r_coeff_data  <= COEFF_W'(r_cand);
            r_coeff_idx   <= r_coeff_cnt[7:0];
            r_coeff_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_coeff_hs) begin
            r_coeff_valid <= 1'b0;
            if (w_last) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_coeff_cnt <= r_coeff_cnt + 9'd1;
            end
          end
        end
        default: begin
          r_coeff_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef REJ_STATS_EN
  logic [15:0] r_rej_count;
  logic [15:0] r_bytes_used;

  // Saturating per-polynomial statistics, held after done until the next start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rej_count  <= 16'd0;
      r_bytes_used <= 16'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_rej_count  <= 16'd0;
      r_bytes_used <= 16'd0;
    end else begin
      if ((r_state == S_CHECK) && !w_cand_ok && (r_rej_count != 16'hFFFF))
        r_rej_count <= r_rej_count + 16'd1;
      if (w_byte_hs && (r_bytes_used != 16'hFFFF))
        r_bytes_used <= r_bytes_used + 16'd1;
    end
  end

  assign rej_count  = r_rej_count;
  assign bytes_used = r_bytes_used;
`endif

  assign in_ready    = r_in_ready;
  assign coeff_data  = r_coeff_data;
  assign coeff_idx   = r_coeff_idx;
  assign coeff_valid = r_coeff_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_rej_ntt_sampler.sv
// Self-checking bench for rej_ntt_sampler: random squeeze streams versus a RejNTTPoly reference.
// Build with REJ_STATS_EN defined to also check the statistics ports.
module tb_rej_ntt_sampler;
  localparam int Q = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        coeff_ready = 1'b0;
  logic        in_ready;
  logic [31:0] coeff_data;
  logic [7:0]  coeff_idx;
  logic        coeff_valid;
  logic        busy;
  logic        done;
`ifdef REJ_STATS_EN
  logic [15:0] rej_count;
  logic [15:0] bytes_used;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] stim_q[$];
  int exp_q[$];
  int exp_bytes;
  int rej_exp;
  int got_data[$];
  int got_idx[$];
  int done_cnt;
  int stable_viol;
  int ready_viol;
  int rd_ptr;

  rej_ntt_sampler dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coeff_data(coeff_data), .coeff_idx(coeff_idx), .coeff_valid(coeff_valid),
    .coeff_ready(coeff_ready), .busy(busy),
`ifdef REJ_STATS_EN
    .rej_count(rej_count), .bytes_used(bytes_used),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference RejNTTPoly: walk whole triples, keep values below Q, stop at 256.
  function automatic void compute_ref();
    int c;
    exp_q.delete();
    exp_bytes = 0;
    rej_exp = 0;
    for (int i = 0; (i + 2 < stim_q.size()) && (exp_q.size() < 256); i += 3) begin
      c = int'(stim_q[i]) + 256 * int'(stim_q[i+1]) + 65536 * (int'(stim_q[i+2]) % 128);
      exp_bytes += 3;
      if (c < Q) exp_q.push_back(c);
      else rej_exp++;
    end
  endfunction

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(255)));
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    coeff_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives stim_q with random gaps/stalls and records what the DUT produced.
  task automatic run_stream(input int gap_pct, input int stall_pct, input int hold_idx,
                            input int stop_after, input int budget);
    logic [31:0] held_data;
    logic [7:0]  held_idx;
    bit held = 0;
    bit fin = 0;
    int hold_used = 0;
    got_data.delete();
    got_idx.delete();
    done_cnt = 0; stable_viol = 0; ready_viol = 0; rd_ptr = 0;
    for (int c = 0; (c < budget) && !fin; c++) begin
      @(negedge clk);
      if (held && coeff_valid && ((coeff_data !== held_data) || (coeff_idx !== held_idx)))
        stable_viol++;
      if (coeff_valid && in_ready) ready_viol++;
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      in_valid = (rd_ptr < stim_q.size()) && (int'($urandom_range(99)) >= gap_pct);
      in_data = in_valid ? stim_q[rd_ptr] : 8'h00;
      if (coeff_valid && (int'(coeff_idx) == hold_idx) && (hold_used < 10)) begin
        coeff_ready = 1'b0;
        hold_used++;
      end else begin
        coeff_ready = (int'($urandom_range(99)) >= stall_pct);
      end
      if (in_valid && in_ready) rd_ptr++;
      if (coeff_valid && coeff_ready) begin
        got_data.push_back(int'(coeff_data));
        got_idx.push_back(int'(coeff_idx));
        held = 0;
        if (got_data.size() == stop_after) fin = 1;
      end else begin
        held = coeff_valid;
        held_data = coeff_data;
        held_idx = coeff_idx;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks += 6;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %0d expected 0", in_ready); end
    if (coeff_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0d expected 0", coeff_valid); end
    if (coeff_data !== 32'd0) begin n_errors++; $display("FAIL reset_data: got %0d expected 0", coeff_data); end
    if (coeff_idx !== 8'd0) begin n_errors++; $display("FAIL reset_idx: got %0d expected 0", coeff_idx); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0d expected 0", done); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL idle_in_ready: got %0d expected 0", in_ready); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %0d expected 0", busy); end
  endtask

  task automatic test_latency();
    do_start();
    n_checks += 2;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL start_busy: got %0d expected 1", busy); end
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL start_in_ready: got %0d expected 1", in_ready); end
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk); in_data = 8'h00;
    @(negedge clk); in_data = 8'h00;
    @(negedge clk); in_valid = 1'b0;
    n_checks++;
    if (coeff_valid !== 1'b0) begin n_errors++; $display("FAIL lat_check_cycle: got %0d expected 0", coeff_valid); end
    @(negedge clk);
    n_checks += 4;
    if (coeff_valid !== 1'b1) begin n_errors++; $display("FAIL lat_valid: got %0d expected 1", coeff_valid); end
    if (coeff_data !== 32'd1) begin n_errors++; $display("FAIL lat_data: got %0d expected 1", coeff_data); end
    if (coeff_idx !== 8'd0) begin n_errors++; $display("FAIL lat_idx: got %0d expected 0", coeff_idx); end
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL lat_in_ready: got %0d expected 0", in_ready); end
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (coeff_valid !== 1'b0) begin n_errors++; $display("FAIL abort_valid: got %0d expected 0", coeff_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %0d expected 0", busy); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_boundary();
    logic [7:0] hdr[12] = '{8'h00, 8'hE0, 8'h7F, 8'h01, 8'hE0, 8'h7F,
                            8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h00, 8'h80};
    stim_q.delete();
    foreach (hdr[i]) stim_q.push_back(hdr[i]);
    add_random(900);
    compute_ref();
    do_start();
    run_stream(0, 0, -1, -1, 20000);
    n_checks += 5;
    if (done_cnt !== 1) begin n_errors++; $display("FAIL bnd_done: got %0d expected 1", done_cnt); end
    if (got_data.size() !== 256) begin n_errors++; $display("FAIL bnd_count: got %0d expected 256", got_data.size()); end
    if ((got_data.size() < 2) || (got_data[0] !== 8380416)) begin n_errors++; $display("FAIL bnd_qminus1: got %0d expected 8380416", (got_data.size() > 0) ? got_data[0] : -1); end
    if ((got_data.size() < 2) || (got_data[1] !== 5)) begin n_errors++; $display("FAIL bnd_masked: got %0d expected 5", (got_data.size() > 1) ? got_data[1] : -1); end
    if (rd_ptr !== exp_bytes) begin n_errors++; $display("FAIL bnd_bytes: got %0d expected %0d", rd_ptr, exp_bytes); end
    for (int i = 0; (i < got_data.size()) && (i < exp_q.size()); i++) begin
      n_checks++;
      if ((got_data[i] !== exp_q[i]) || (got_idx[i] !== i)) begin
        n_errors++;
        $display("FAIL bnd_coeff[%0d]: got %0d@%0d expected %0d@%0d", i, got_data[i], got_idx[i], exp_q[i], i);
      end
    end
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if ((in_ready !== 1'b0) || (busy !== 1'b0) || (done !== 1'b0)) begin
        n_errors++;
        $display("FAIL post_done: got in_ready=%0d busy=%0d done=%0d expected 0 0 0", in_ready, busy, done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stream(input int gap_pct, input int stall_pct, input int hold_idx);
    stim_q.delete();
    add_random(1000);
    compute_ref();
    do_start();
    run_stream(gap_pct, stall_pct, hold_idx, -1, 30000);
    n_checks += 5;
    if (done_cnt !== 1) begin n_errors++; $display("FAIL strm_done: got %0d expected 1", done_cnt); end
    if (got_data.size() !== exp_q.size()) begin n_errors++; $display("FAIL strm_count: got %0d expected %0d", got_data.size(), exp_q.size()); end
    if (rd_ptr !== exp_bytes) begin n_errors++; $display("FAIL strm_bytes: got %0d expected %0d", rd_ptr, exp_bytes); end
    if (stable_viol !== 0) begin n_errors++; $display("FAIL strm_stable: got %0d expected 0", stable_viol); end
    if (ready_viol !== 0) begin n_errors++; $display("FAIL strm_in_ready_emit: got %0d expected 0", ready_viol); end
    for (int i = 0; (i < got_data.size()) && (i < exp_q.size()); i++) begin
      n_checks++;
      if ((got_data[i] !== exp_q[i]) || (got_idx[i] !== i)) begin
        n_errors++;
        $display("FAIL strm_coeff[%0d]: got %0d@%0d expected %0d@%0d", i, got_data[i], got_idx[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_full_random();
    test_stream(30, 0, -1);
  endtask

  task automatic test_backpressure();
    test_stream(40, 30, 5);
  endtask

  task automatic test_reset_mid();
    stim_q.delete();
    add_random(1000);
    compute_ref();
    do_start();
    run_stream(10, 10, -1, 101, 20000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (got_data.size() !== 101) begin n_errors++; $display("FAIL mid_count: got %0d expected 101", got_data.size()); end
    if ({in_ready, coeff_valid, coeff_data, coeff_idx, busy, done} !== 44'd0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: got rdy=%0d v=%0d d=%0d i=%0d b=%0d dn=%0d expected all 0",
               in_ready, coeff_valid, coeff_data, coeff_idx, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    do_start();
    run_stream(0, 0, -1, -1, 20000);
    n_checks += 2;
    if (done_cnt !== 1) begin n_errors++; $display("FAIL mid_done: got %0d expected 1", done_cnt); end
    if (got_data.size() !== exp_q.size()) begin n_errors++; $display("FAIL mid_count2: got %0d expected %0d", got_data.size(), exp_q.size()); end
    for (int i = 0; (i < got_data.size()) && (i < exp_q.size()); i++) begin
      n_checks++;
      if ((got_data[i] !== exp_q[i]) || (got_idx[i] !== i)) begin
        n_errors++;
        $display("FAIL mid_coeff[%0d]: got %0d@%0d expected %0d@%0d", i, got_data[i], got_idx[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_stats();
    logic [7:0] rej[9] = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hE0, 8'h7F, 8'h10, 8'hF0, 8'hFF};
    int v;
    stim_q.delete();
    foreach (rej[i]) stim_q.push_back(rej[i]);
    for (int i = 0; i < 256; i++) begin
      v = int'($urandom_range(Q - 1));
      stim_q.push_back(8'(v));
      stim_q.push_back(8'(v >> 8));
      stim_q.push_back({1'($urandom_range(1)), 7'(v >> 16)});
    end
    add_random(30);
    compute_ref();
    do_start();
    run_stream(20, 20, -1, -1, 20000);
    n_checks += 4;
    if (rej_exp !== 3) begin n_errors++; $display("FAIL stats_model_rej: got %0d expected 3", rej_exp); end
    if (done_cnt !== 1) begin n_errors++; $display("FAIL stats_done: got %0d expected 1", done_cnt); end
    if (rd_ptr !== 777) begin n_errors++; $display("FAIL stats_bytes_taken: got %0d expected 777", rd_ptr); end
    if (got_data.size() !== 256) begin n_errors++; $display("FAIL stats_count: got %0d expected 256", got_data.size()); end
    for (int i = 0; (i < got_data.size()) && (i < exp_q.size()); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL stats_coeff[%0d]: got %0d expected %0d", i, got_data[i], exp_q[i]);
      end
    end
`ifdef REJ_STATS_EN
    repeat (3) @(negedge clk);
    n_checks += 2;
    if (rej_count !== 16'd3) begin n_errors++; $display("FAIL rej_count: got %0d expected 3", rej_count); end
    if (bytes_used !== 16'd777) begin n_errors++; $display("FAIL bytes_used: got %0d expected 777", bytes_used); end
`endif
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_boundary();
    test_full_random();
    test_backpressure();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
